// File: rtl/tdm_frame_checker.sv
// TDM frame monitor: deserialises expected and actual serial streams, queues expected
// frames in a small FIFO and compares actual frames against the head in arrival order.
module tdm_frame_checker #(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned ADDR  = 2
) (
    input  logic            sclk,
    input  logic            rstn,
    input  logic            exp_sdata,
    input  logic            exp_sfs,
    input  logic            act_sdata,
    input  logic            act_sfs,
    output logic [ADDR:0]   exp_level,
    output logic            exp_empty,
    output logic            exp_full,
    output logic            test_pass,
    output logic [15:0]     match_cnt,
    output logic [15:0]     err_cnt
);

    localparam int unsigned CW    = $clog2(WIDTH);
    localparam int unsigned DEPTH = 2 ** ADDR;
    localparam logic [ADDR:0]  LvlFull = (ADDR + 1)'(DEPTH);
    localparam logic [CW-1:0]  CntLast = CW'(WIDTH - 1);

    typedef enum logic {StIdle, StShift} des_state_e;

    // Index 0 is the expected stream, index 1 the actual stream.
    logic              w_sdata   [2];
    logic              w_sfs     [2];
    des_state_e        r_state   [2];
    des_state_e        w_state_d [2];
    logic [CW-1:0]     r_cnt     [2];
    logic [CW-1:0]     w_cnt_d   [2];
    logic [WIDTH-1:0]  r_frame   [2];
    logic [WIDTH-1:0]  w_frame_d [2];
    logic              r_pvalid  [2];
    logic              w_pvalid_d[2];

    assign w_sdata[0] = exp_sdata;
    assign w_sdata[1] = act_sdata;
    assign w_sfs[0]   = exp_sfs;
    assign w_sfs[1]   = act_sfs;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_state_d[i]  = r_state[i];
            w_cnt_d[i]    = r_cnt[i];
            w_frame_d[i]  = r_frame[i];
            w_pvalid_d[i] = 1'b0;
            if (w_sfs[i]) begin
                // Frame sync always restarts; any partial frame is abandoned.
                w_state_d[i] = StShift;
                w_cnt_d[i]   = CW'(1);
                w_frame_d[i] = {{(WIDTH - 1){1'b0}}, w_sdata[i]};
            end else if (r_state[i] == StShift) begin
                w_frame_d[i] = {r_frame[i][WIDTH-2:0], w_sdata[i]};
                w_cnt_d[i]   = r_cnt[i] + CW'(1);
                if (r_cnt[i] == CntLast) begin
                    w_state_d[i]  = StIdle;
                    w_cnt_d[i]    = '0;
                    w_pvalid_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sclk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rstn) begin
                r_state[i]  <= StIdle;
                r_cnt[i]    <= '0;
                r_pvalid[i] <= 1'b0;
            end else begin
                r_state[i]  <= w_state_d[i];
                r_cnt[i]    <= w_cnt_d[i];
                r_pvalid[i] <= w_pvalid_d[i];
            end
            r_frame[i] <= w_frame_d[i];
        end
    end

    // Expected-frame FIFO and checker.
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR-1:0]  r_wptr;
    logic [ADDR-1:0]  r_rptr;
    logic [ADDR:0]    r_level;
    logic [ADDR:0]    w_level_d;
    logic             r_empty;
    logic             r_full;
    logic             r_pass;
    logic [15:0]      r_match_cnt;
    logic [15:0]      r_err_cnt;
    logic [15:0]      w_match_d;
    logic [15:0]      w_err_d;
    logic [16:0]      w_err_sum;
    logic [1:0]       w_err_inc;
    logic [WIDTH-1:0] w_head;
    logic             w_push;
    logic             w_act_valid;
    logic             w_pop;
    logic             w_overflow;
    logic             w_do_push;
    logic             w_mismatch;
    logic             w_match;
    logic             w_unexp;

    assign w_push      = r_pvalid[0];
    assign w_act_valid = r_pvalid[1];
    assign w_head      = r_mem[r_rptr];
    assign w_pop       = w_act_valid & ~r_empty;
    assign w_overflow  = w_push & r_full & ~w_pop;
    assign w_do_push   = w_push & ~w_overflow;
    assign w_mismatch  = w_pop & (r_frame[1] != w_head);
    assign w_match     = w_pop & ~w_mismatch;
    assign w_unexp     = w_act_valid & r_empty;
    assign w_err_inc   = {1'b0, w_overflow} + {1'b0, (w_mismatch | w_unexp)};

    always_comb begin
        w_level_d = r_level;
        unique case ({w_do_push, w_pop})
            2'b10:   w_level_d = r_level + (ADDR + 1)'(1);
            2'b01:   w_level_d = r_level - (ADDR + 1)'(1);
            default: w_level_d = r_level;
        endcase

        w_err_sum = {1'b0, r_err_cnt} + {15'd0, w_err_inc};
        w_err_d   = w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];

        w_match_d = r_match_cnt;
        if (w_match && (r_match_cnt != 16'hFFFF)) begin
            w_match_d = r_match_cnt + 16'd1;
        end
    end

    always_ff @(posedge sclk) begin
        if (rstn && w_do_push) begin
            r_mem[r_wptr] <= r_frame[0];
        end
    end

    always_ff @(posedge sclk) begin
        if (!rstn) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_pass      <= 1'b1;
            r_match_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + ADDR'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + ADDR'(1);
            end
            r_level     <= w_level_d;
            r_empty     <= (w_level_d == '0);
            r_full      <= (w_level_d == LvlFull);
            r_match_cnt <= w_match_d;
            r_err_cnt   <= w_err_d;
            if (w_err_inc != 2'd0) begin
                r_pass <= 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge sclk) begin
        if (rstn && w_mismatch) begin
            $display("%0t tdm_frame_checker: compare error exp=%h act=%h",
                     $time, w_head, r_frame[1]);
        end
    end
`endif

    assign exp_level = r_level;
    assign exp_empty = r_empty;
    assign exp_full  = r_full;
    assign test_pass = r_pass;
    assign match_cnt = r_match_cnt;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_tdm_frame_checker.sv
// Directed bench for tdm_frame_checker: match, mismatch, overflow, back-to-back,
// resync and unexpected-frame scenarios with hand-computed counter values.
module tb_tdm_frame_checker;

    logic        sclk;
    logic        rstn;
    logic        exp_sdata;
    logic        exp_sfs;
    logic        act_sdata;
    logic        act_sfs;
    logic [2:0]  exp_level;
    logic        exp_empty;
    logic        exp_full;
    logic        test_pass;
    logic [15:0] match_cnt;
    logic [15:0] err_cnt;

    int checks;
    int errors;

    logic [255:0] fr [5];

    tdm_frame_checker #(
        .WIDTH (256),
        .ADDR  (2)
    ) dut (
        .sclk      (sclk),
        .rstn      (rstn),
        .exp_sdata (exp_sdata),
        .exp_sfs   (exp_sfs),
        .act_sdata (act_sdata),
        .act_sfs   (act_sfs),
        .exp_level (exp_level),
        .exp_empty (exp_empty),
        .exp_full  (exp_full),
        .test_pass (test_pass),
        .match_cnt (match_cnt),
        .err_cnt   (err_cnt)
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    // Inputs change on the falling edge; checks also happen there.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge sclk);
            exp_sdata = 1'b0;
            exp_sfs   = 1'b0;
            act_sdata = 1'b0;
            act_sfs   = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge sclk);
        rstn = 1'b0;
        idle(3);
        rstn = 1'b1;
        idle(1);
    endtask

    task automatic send_exp(input logic [255:0] f);
        for (int c = 0; c < 256; c++) begin
            @(negedge sclk);
            exp_sfs   = (c == 0);
            exp_sdata = f[255-c];
            act_sfs   = 1'b0;
            act_sdata = 1'b0;
        end
    endtask

    task automatic send_act(input logic [255:0] f, input int nbits);
        for (int c = 0; c < nbits; c++) begin
            @(negedge sclk);
            act_sfs   = (c == 0);
            act_sdata = f[255-c];
            exp_sfs   = 1'b0;
            exp_sdata = 1'b0;
        end
    endtask

    task automatic run(input logic [255:0] ef, input int es,
                       input logic [255:0] af, input int ast, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge sclk);
            exp_sfs   = (c == es);
            exp_sdata = (c >= es && c < es + 256) ? ef[255-(c-es)] : 1'b0;
            act_sfs   = (c == ast);
            act_sdata = (c >= ast && c < ast + 256) ? af[255-(c-ast)] : 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (test_pass !== 1'b1) begin errors++;
            $display("FAIL reset_pass got %0b want 1", test_pass); end
        checks++; if (match_cnt !== 16'd0) begin errors++;
            $display("FAIL reset_match got %0d want 0", match_cnt); end
        checks++; if (err_cnt !== 16'd0) begin errors++;
            $display("FAIL reset_err got %0d want 0", err_cnt); end
        checks++; if (exp_empty !== 1'b1) begin errors++;
            $display("FAIL reset_empty got %0b want 1", exp_empty); end
        checks++; if (exp_full !== 1'b0) begin errors++;
            $display("FAIL reset_full got %0b want 0", exp_full); end
        checks++; if (exp_level !== 3'd0) begin errors++;
            $display("FAIL reset_level got %0d want 0", exp_level); end
    endtask

    task automatic test_match();
        logic [255:0] f;
        f = {32{8'hA5}};
        do_reset();
        // Act last bit sits at cycle 265; pvalid follows, counter one cycle later.
        run(f, 0, f, 10, 266);
        idle(1);
        checks++; if (match_cnt !== 16'd0) begin errors++;
            $display("FAIL match_latency got %0d want 0", match_cnt); end
        checks++; if (exp_level !== 3'd1) begin errors++;
            $display("FAIL match_level_queued got %0d want 1", exp_level); end
        idle(1);
        checks++; if (match_cnt !== 16'd1) begin errors++;
            $display("FAIL match_cnt got %0d want 1", match_cnt); end
        checks++; if (err_cnt !== 16'd0) begin errors++;
            $display("FAIL match_err got %0d want 0", err_cnt); end
        checks++; if (test_pass !== 1'b1) begin errors++;
            $display("FAIL match_pass got %0b want 1", test_pass); end
        checks++; if (exp_empty !== 1'b1) begin errors++;
            $display("FAIL match_empty got %0b want 1", exp_empty); end
    endtask

    task automatic test_mismatch();
        logic [255:0] f;
        f = {32{8'hA5}};
        do_reset();
        run(256'h1, 0, 256'h3, 10, 266);
        idle(2);
        checks++; if (err_cnt !== 16'd1) begin errors++;
            $display("FAIL mismatch_err got %0d want 1", err_cnt); end
        checks++; if (test_pass !== 1'b0) begin errors++;
            $display("FAIL mismatch_pass got %0b want 0", test_pass); end
        checks++; if (match_cnt !== 16'd0) begin errors++;
            $display("FAIL mismatch_match got %0d want 0", match_cnt); end
        checks++; if (exp_empty !== 1'b1) begin errors++;
            $display("FAIL mismatch_empty got %0b want 1", exp_empty); end
        run(f, 0, f, 10, 266);
        idle(2);
        checks++; if (match_cnt !== 16'd1) begin errors++;
            $display("FAIL sticky_match got %0d want 1", match_cnt); end
        checks++; if (test_pass !== 1'b0) begin errors++;
            $display("FAIL sticky_pass got %0b want 0", test_pass); end
        checks++; if (err_cnt !== 16'd1) begin errors++;
            $display("FAIL sticky_err got %0d want 1", err_cnt); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) send_exp(fr[i]);
        idle(2);
        checks++; if (exp_level !== 3'd4) begin errors++;
            $display("FAIL ovf_level got %0d want 4", exp_level); end
        checks++; if (exp_full !== 1'b1) begin errors++;
            $display("FAIL ovf_full got %0b want 1", exp_full); end
        checks++; if (err_cnt !== 16'd0) begin errors++;
            $display("FAIL ovf_err_before got %0d want 0", err_cnt); end
        send_exp(fr[4]);
        idle(2);
        checks++; if (err_cnt !== 16'd1) begin errors++;
            $display("FAIL ovf_err got %0d want 1", err_cnt); end
        checks++; if (test_pass !== 1'b0) begin errors++;
            $display("FAIL ovf_pass got %0b want 0", test_pass); end
        checks++; if (exp_level !== 3'd4) begin errors++;
            $display("FAIL ovf_level_after got %0d want 4", exp_level); end
        for (int i = 0; i < 4; i++) send_act(fr[i], 256);
        idle(2);
        checks++; if (match_cnt !== 16'd4) begin errors++;
            $display("FAIL order_match got %0d want 4", match_cnt); end
        checks++; if (err_cnt !== 16'd1) begin errors++;
            $display("FAIL order_err got %0d want 1", err_cnt); end
        checks++; if (exp_empty !== 1'b1) begin errors++;
            $display("FAIL order_empty got %0b want 1", exp_empty); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) send_exp(fr[i]);
        // Push into a full FIFO while the same cycle pops: no drop, level unchanged.
        run(fr[4], 0, fr[0], 0, 256);
        idle(2);
        checks++; if (exp_level !== 3'd4) begin errors++;
            $display("FAIL b2b_level got %0d want 4", exp_level); end
        checks++; if (exp_full !== 1'b1) begin errors++;
            $display("FAIL b2b_full got %0b want 1", exp_full); end
        checks++; if (err_cnt !== 16'd0) begin errors++;
            $display("FAIL b2b_err got %0d want 0", err_cnt); end
        checks++; if (match_cnt !== 16'd1) begin errors++;
            $display("FAIL b2b_match got %0d want 1", match_cnt); end
        for (int i = 1; i < 5; i++) send_act(fr[i], 256);
        idle(2);
        checks++; if (match_cnt !== 16'd5) begin errors++;
            $display("FAIL b2b_drain_match got %0d want 5", match_cnt); end
        checks++; if (err_cnt !== 16'd0) begin errors++;
            $display("FAIL b2b_drain_err got %0d want 0", err_cnt); end
        checks++; if (test_pass !== 1'b1) begin errors++;
            $display("FAIL b2b_pass got %0b want 1", test_pass); end
        checks++; if (exp_empty !== 1'b1) begin errors++;
            $display("FAIL b2b_empty got %0b want 1", exp_empty); end
    endtask

    task automatic test_resync();
        logic [255:0] r;
        r = {4{64'h0123_4567_89AB_CDEF}};
        do_reset();
        send_exp(r);
        idle(2);
        send_act(~r, 100);
        send_act(r, 256);
        idle(2);
        checks++; if (match_cnt !== 16'd1) begin errors++;
            $display("FAIL resync_match got %0d want 1", match_cnt); end
        checks++; if (err_cnt !== 16'd0) begin errors++;
            $display("FAIL resync_err got %0d want 0", err_cnt); end
        checks++; if (test_pass !== 1'b1) begin errors++;
            $display("FAIL resync_pass got %0b want 1", test_pass); end
        checks++; if (exp_empty !== 1'b1) begin errors++;
            $display("FAIL resync_empty got %0b want 1", exp_empty); end
    endtask

    task automatic test_unexpected();
        do_reset();
        send_act({8{32'hDEAD_BEEF}}, 256);
        idle(2);
        checks++; if (err_cnt !== 16'd1) begin errors++;
            $display("FAIL unexp_err got %0d want 1", err_cnt); end
        checks++; if (test_pass !== 1'b0) begin errors++;
            $display("FAIL unexp_pass got %0b want 0", test_pass); end
        checks++; if (exp_level !== 3'd0) begin errors++;
            $display("FAIL unexp_level got %0d want 0", exp_level); end
        checks++; if (match_cnt !== 16'd0) begin errors++;
            $display("FAIL unexp_match got %0d want 0", match_cnt); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rstn      = 1'b0;
        exp_sdata = 1'b0;
        exp_sfs   = 1'b0;
        act_sdata = 1'b0;
        act_sfs   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fr[i] = {8{32'hC0DE_0000 + 32'(i)}};
        end
        test_reset();
        test_match();
        test_mismatch();
        test_overflow();
        test_back_to_back();
        test_resync();
        test_unexpected();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
